// File: rtl/is_uart_ascii_hex_parser_pkg.sv
// Shared UART controller definitions: byte width, ASCII terminators and the
// state/error encodings used by the hex line parser.
package is_pkg_uart_controller;

   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] ASCII_CR = 8'h0D;
   localparam logic [DATA_W-1:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD,
      FLUSH
   } parser_state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_BAD_CHAR,
      ERR_OVERFLOW,
      ERR_OVERRUN
   } parser_err_t;

   function automatic logic is_term(input logic [DATA_W-1:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

endpackage

// File: rtl/is_uart_ascii_hex_parser_dec.sv
// Combinational ASCII hex digit decoder; accepts both letter cases and
// returns nibble 0 with is_hex_o low for anything else.
module is_uart_dec_ascii_hex
   import is_pkg_uart_controller::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [3:0]        nibble_o,
   output logic              is_hex_o
);

   always_comb begin
      nibble_o = 4'h0;
      is_hex_o = 1'b0;
      if (data_i >= 8'h30 && data_i <= 8'h39) begin
         nibble_o = data_i[3:0];
         is_hex_o = 1'b1;
      end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                   (data_i >= 8'h61 && data_i <= 8'h66)) begin
         // 'A'/'a' carry 1 in their low nibble, so +9 lands on 10
         nibble_o = data_i[3:0] + 4'd9;
         is_hex_o = 1'b1;
      end
   end

endmodule

// File: rtl/is_uart_ascii_hex_parser.sv
// Accumulates ASCII hex digits MSB-first and emits the word on CR/LF;
// malformed lines raise one error pulse and are flushed to the terminator.
module is_uart_ascii_hex_parser
   import is_pkg_uart_controller::*;
#(
   parameter int NIBBLES = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [DATA_W-1:0]            rx_data_i,
   input  logic                         rx_valid_i,
   output logic [4*NIBBLES-1:0]         word_o,
   output logic                         word_valid_o,
   input  logic                         word_ready_i,
   output logic [$clog2(NIBBLES+1)-1:0] nibble_cnt_o,
   output logic                         err_o,
   output logic [1:0]                   err_code_o,
   output parser_state_t                state_o
);

   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = $clog2(NIBBLES + 1);

   // Handshake: word_o/word_valid_o stay stable while valid and not ready;
   // a transfer happens in any cycle where word_valid_o && word_ready_i.

   parser_state_t    state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     word_q, word_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   parser_err_t      code_q, code_d;

   logic [3:0] nib;
   logic       is_hex;
   logic       dig, term, bad, idle_like, full;

   is_uart_dec_ascii_hex u_dec (
      .data_i   (rx_data_i),
      .nibble_o (nib),
      .is_hex_o (is_hex)
   );

   assign dig  = rx_valid_i && is_hex;
   assign term = rx_valid_i && is_term(rx_data_i);
   assign bad  = rx_valid_i && !is_hex && !is_term(rx_data_i);
   assign full = (cnt_q == CNT_W'(NIBBLES));
   // A completed handshake frees the byte in the same cycle to act as in IDLE
   assign idle_like = (state_q == IDLE) || (state_q == HOLD && word_ready_i);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dig)      state_d = ACCUM;
            else if (bad) state_d = FLUSH;
         end
         ACCUM: begin
            if (dig)       state_d = full ? FLUSH : ACCUM;
            else if (term) state_d = HOLD;
            else if (bad)  state_d = FLUSH;
         end
         HOLD: begin
            if (word_ready_i) begin
               if (dig)      state_d = ACCUM;
               else if (bad) state_d = FLUSH;
               else          state_d = IDLE;
            end
         end
         FLUSH: begin
            if (term) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      code_d  = code_q;

      if (state_q == HOLD) begin
         if (word_ready_i) begin
            valid_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
         end else if (rx_valid_i) begin
            err_d  = 1'b1;
            code_d = ERR_OVERRUN;
         end
      end

      if (idle_like) begin
         if (dig) begin
            acc_d = W'(nib);
            cnt_d = CNT_W'(1);
         end else if (bad) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CHAR;
         end
      end

      if (state_q == ACCUM) begin
         if (dig && full) begin
            err_d  = 1'b1;
            code_d = ERR_OVERFLOW;
            acc_d  = '0;
            cnt_d  = '0;
         end else if (dig) begin
            acc_d = {acc_q[W-5:0], nib};
            cnt_d = cnt_q + CNT_W'(1);
         end else if (term) begin
            word_d  = acc_q;
            valid_d = 1'b1;
         end else if (bad) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CHAR;
            acc_d  = '0;
            cnt_d  = '0;
         end
      end

      if (state_q == FLUSH && term) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = valid_q;
   assign nibble_cnt_o = cnt_q;
   assign err_o        = err_q;
   assign err_code_o   = code_q;
   assign state_o      = state_q;

endmodule

// File: doc/is_uart_ascii_hex_parser.md
Name: is_uart_ascii_hex_parser

Overview:
Receive-side counterpart of the UART hex-to-ASCII transmit path. It consumes bytes from the UART receiver and accepts ASCII hex digits ('0'-'9', 'A'-'F', 'a'-'f'). It accumulates the digits MSB-first into a word and emits that word on a valid/ready interface when the line terminator (CR or LF) arrives. Malformed lines are flagged and discarded, so downstream command logic sees only clean binary words.

Parameters:
NIBBLES, 8, maximum hex digits per word; output width is 4*NIBBLES bits.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  synchronous reset, active-low
rx_data_i  input  DATA_W  received byte from the UART receiver
rx_valid_i  input  1  one-cycle strobe: rx_data_i is valid
word_o  output  4*NIBBLES  parsed word, right-aligned, zero-extended
word_valid_o  output  1  word_o is valid; held until accepted
word_ready_i  input  1  downstream accepts word_o
nibble_cnt_o  output  $clog2(NIBBLES+1)  digits captured in the current line
err_o  output  1  one-cycle error pulse
err_code_o  output  2  error cause, valid with err_o: 1 BAD_CHAR, 2 OVERFLOW, 3 OVERRUN; holds its last value otherwise

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low on rst_n_i.
- Reset (rst_n_i=0 at a clk_i edge):
  - state IDLE; accumulator, count and word_o cleared to 0;
  - word_valid_o=0, err_o=0, err_code_o=0.
  - Applies mid-line and while a word is pending; the pending word is lost.
- rx has no backpressure. Every rx_valid_i byte is consumed in the cycle it arrives.
- Character classes:
  - digit: converted to a nibble;
  - terminator: 0x0D or 0x0A;
  - everything else: bad.
- FSM states: IDLE, ACCUM, HOLD, FLUSH.
- IDLE:
  - digit -> acc={0,nib}, cnt=1, go ACCUM;
  - terminator -> ignored, so the second byte of a CRLF pair and empty lines do nothing;
  - bad -> err BAD_CHAR, go FLUSH.
- ACCUM:
  - digit with cnt<NIBBLES -> acc={acc[4N-5:0],nib}, cnt+1;
  - digit with cnt==NIBBLES -> err OVERFLOW, go FLUSH;
  - terminator -> word_o=acc, word_valid_o=1 from the next cycle (1-cycle latency), go HOLD;
  - bad -> err BAD_CHAR, go FLUSH.
- HOLD:
  - word_o and word_valid_o are stable until word_ready_i=1.
  - Handshake cycle: word_valid_o=0 next cycle, acc and cnt cleared, go IDLE.
  - rx_valid_i without handshake in the same cycle: byte dropped, err OVERRUN, stay HOLD.
  - rx_valid_i together with word_ready_i: handshake completes and the byte is processed exactly as in IDLE.
- FLUSH:
  - all bytes are discarded until a terminator arrives; the terminator moves the FSM to IDLE with acc and cnt cleared;
  - no further err pulses for the rest of that line.
- err_o is registered: it is high in the cycle after the offending byte, for exactly one cycle.
- nibble_cnt_o mirrors cnt. It reads 0 in IDLE and FLUSH and keeps the final count in HOLD.
- word_valid_o never rises spontaneously. It only rises after a terminator in ACCUM.

Decomposition:
- Package is_pkg_uart_controller gains:
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - typedef enum parser_state_t {IDLE, ACCUM, HOLD, FLUSH};
  - typedef enum logic[1:0] parser_err_t {ERR_NONE, ERR_BAD_CHAR, ERR_OVERFLOW, ERR_OVERRUN}.
- The package's existing DATA_W sets the width of rx_data_i.
- One combinational sub-module, is_uart_dec_ascii_hex: byte in, outputs nibble[3:0] and is_hex. It accepts upper and lower case; for non-hex input, nibble=0 and is_hex=0.

Test Plan:
- Bytes "1A2b\r" with word_ready_i=1 -> word_o=32'h00001A2B, word_valid_o high 1 cycle after CR, nibble_cnt_o=4, err_o never asserted.
- "DEADBEEF\r\n" with ready held low 5 cycles, then high -> word_o=32'hDEADBEEF, stable for all 6 valid cycles; the LF arrives during HOLD (no handshake) and gives err OVERRUN (3). Separately, a CRLF with ready=1 during the LF cycle produces no error and no second word.
- "123456789\r" -> err_o pulse code 2 (OVERFLOW) after the 9th digit, no word emitted; then "5\r" -> word_o=32'h5.
- "12G4\n" -> err code 1 (BAD_CHAR) one cycle after 'G', no further errors, no word; then "FF\n" -> word_o=32'hFF.
- Word pending, byte '7' arrives in the same cycle as word_ready_i=1 -> handshake completes, FSM in ACCUM with cnt=1; "\r" -> word_o=32'h7.
- "AB" then rst_n_i=0 for 1 cycle, then "C\r" -> all outputs 0 during reset; word_o=32'hC (not 32'hABC).
